// File: rtl/controle_rr.sv
// Round-robin scheduler/sequencer sharing one BOBC datapath among N_REQ requesters.
// Walks the fixed load/compute/store control sequence, then waits for pronto with a timeout.
module controle_rr #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int WAIT_MAX = 15
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             pronto,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] ack,
  output logic             err,
  output logic [ID_W-1:0]  sel_id,
  output logic             busy,
  output logic             lx,
  output logic [1:0]       m0,
  output logic [1:0]       m1,
  output logic [1:0]       m2,
  output logic             h,
  output logic             lh,
  output logic             ls
);

  typedef enum logic [3:0] {
    IDLE, LOAD, H1, S2, H2, S3, H3, S4, ST, WAITP, DONE
  } state_t;

  typedef struct packed {
    logic       lx;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       lh;
    logic       ls;
  } ctrl_t;

  localparam logic [7:0]      WAIT_LAST = 8'(WAIT_MAX - 1);
  localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      LOAD: begin c.lx = 1'b1; c.m0 = 2'b01; c.h = 1'b1; end
      H1:   begin c.m0 = 2'b01; c.h = 1'b1; c.lh = 1'b1; end
      S2:   begin c.m0 = 2'b10; c.m2 = 2'b11; end
      H2:   begin c.m0 = 2'b10; c.m2 = 2'b11; c.lh = 1'b1; end
      S3:   begin c.m1 = 2'b01; c.m2 = 2'b11; c.h = 1'b1; end
      H3:   begin c.m1 = 2'b01; c.m2 = 2'b11; c.h = 1'b1; c.lh = 1'b1; end
      S4:   begin c.m0 = 2'b11; c.m2 = 2'b11; end
      ST:   begin c.m0 = 2'b11; c.m2 = 2'b11; c.ls = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_out_q, err_out_d;
  logic [ID_W-1:0]  sel_q, sel_d;
  logic             busy_q, busy_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [N_REQ-1:0] onehot_d;

  // Round-robin pick: lowest set bit above the pointer wins, else lowest set bit at or below it.
  logic             found_hi;
  logic [ID_W-1:0]  win_hi, win_lo, winner;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        if (ID_W'(j) > ptr_q) begin
          found_hi = 1'b1;
          win_hi   = ID_W'(j);
        end else begin
          win_lo   = ID_W'(j);
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          ptr_d   = winner;
          state_d = LOAD;
        end
      end
      LOAD: state_d = H1;
      H1:   state_d = S2;
      S2:   state_d = H2;
      H2:   state_d = S3;
      S3:   state_d = H3;
      H3:   state_d = S4;
      S4:   state_d = ST;
      ST: begin
        state_d = WAITP;
        wait_d  = '0;
      end
      WAITP: begin
        // pronto takes precedence over the timeout in the same cycle
        if (pronto) begin
          state_d = DONE;
          err_d   = 1'b0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track state_q exactly.
  always_comb begin
    ctrl_d    = ctrl_of(state_d);
    busy_d    = (state_d != IDLE);
    onehot_d  = ONE << ptr_d;
    gnt_d     = busy_d ? onehot_d : '0;
    ack_d     = (state_d == DONE) ? onehot_d : '0;
    err_out_d = (state_d == DONE) && err_d;
    sel_d     = busy_d ? ptr_d : '0;
  end

  // NOTE: reset is synchronous here, so it is sampled only at the clock edge like any other input.
  always_ff @(posedge ck) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= ID_W'(N_REQ - 1);
      wait_q    <= '0;
      err_q     <= 1'b0;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_out_q <= 1'b0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      err_out_q <= err_out_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign gnt    = gnt_q;
  assign ack    = ack_q;
  assign err    = err_out_q;
  assign sel_id = sel_q;
  assign busy   = busy_q;
  assign lx     = ctrl_q.lx;
  assign m0     = ctrl_q.m0;
  assign m1     = ctrl_q.m1;
  assign m2     = ctrl_q.m2;
  assign h      = ctrl_q.h;
  assign lh     = ctrl_q.lh;
  assign ls     = ctrl_q.ls;

endmodule

// File: doc/controle_rr.md
Name: controle_rr

Overview:
- Round-robin scheduler and sequencer that shares one BOBC datapath among N_REQ requesters.
- Grants one requester at a time and drives the datapath control word (lx, m0, m1, m2, h, lh, ls) through the fixed load/compute/store sequence.
- Waits for the datapath `pronto` with a timeout, then returns a one-cycle ack (plus err on timeout) to the granted requester.

Parameters:
- N_REQ, 4, number of requesters (2..4).
- ID_W, 2, width of sel_id; must satisfy 2^ID_W >= N_REQ.
- WAIT_MAX, 15, max WAITP cycles without `pronto` before timeout (1..255).

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  N_REQ  per-requester job request, level; held until that requester's ack.
- pronto  in  1  datapath result ready, sampled only in WAITP.
- gnt  out  N_REQ  one-hot grant, held from LOAD through DONE.
- ack  out  N_REQ  one-cycle completion pulse on the granted bit.
- err  out  1  timeout flag, pulses with ack.
- sel_id  out  ID_W  index of granted requester, valid while busy.
- busy  out  1  high whenever state != IDLE.
- lx  out  1  datapath input register load.
- m0  out  2  datapath mux 0 select.
- m1  out  2  datapath mux 1 select.
- m2  out  2  datapath mux 2 select.
- h  out  1  datapath operation select.
- lh  out  1  datapath accumulator register load.
- ls  out  1  datapath output register load.

Behaviour:
- **Reset.** rst=0 at a rising edge:
  - state goes to IDLE and wait counter clears.
  - rr pointer goes to N_REQ-1, so req[0] has top priority next.
  - Reset overrides any state, including mid-job; no ack is issued for an aborted job.
- **Reset output values.** All outputs are 0: gnt, ack, err, sel_id, busy, lx, h, lh, ls, and all m* = 00.
- **Output timing.** All outputs decode from the registered state only (Moore). Outputs not listed for a state are 0.
- **IDLE.** Outputs all 0.
  - If req != 0: pick the first set bit searching from pointer+1 upward, wrapping at N_REQ.
  - Register the winner into sel_id and the pointer, then go to LOAD.
  - Otherwise stay in IDLE.
- **Sequence states.** Each lasts exactly 1 cycle, in this order:
  - LOAD: lx=1, m0=01, h=1.
  - H1: m0=01, h=1, lh=1.
  - S2: m0=10, m2=11.
  - H2: m0=10, m2=11, lh=1.
  - S3: m1=01, m2=11, h=1.
  - H3: m1=01, m2=11, h=1, lh=1.
  - S4: m0=11, m2=11.
  - ST: m0=11, m2=11, ls=1.
  - ST goes to WAITP with the wait counter cleared.
- **WAITP.** Control word is all 0.
  - If pronto=1: go to DONE, err_next=0.
  - Else if counter == WAIT_MAX-1: go to DONE, err_next=1.
  - Else: counter increments and state stays in WAITP.
  - A pronto that arrives in the same cycle the counter hits its limit wins: no error.
- **DONE.** ack[sel_id]=1 and err=err_latched for exactly 1 cycle, then IDLE.
- **Grant and busy.** gnt[sel_id]=1 in LOAD..DONE inclusive. busy=1 in every non-IDLE state.
- **req changes mid-job.** Deasserting req of the granted requester mid-job does not abort; the job completes and ack is still pulsed. Requests from other requesters are only sampled in IDLE.
- **Latency.** With req sampled in IDLE at cycle 0 and pronto=1:
  - LOAD at cycle 1, ST at cycle 8, WAITP at cycle 9.
  - ack at cycle 10, IDLE at cycle 11.
  - Minimum job-to-job spacing is 11 cycles.
- **Back-to-back requests.** A req still high in the IDLE cycle right after ack is treated as a new request. Round-robin ensures every other pending requester is served first.
- **Timeout.** With pronto stuck at 0, WAITP lasts exactly WAIT_MAX cycles, then DONE with err=1.
- **Widths.** Wait counter is 8 bits. Pointer and sel_id are ID_W bits. Req bits at or above N_REQ do not exist.

Test Plan:
- Reset check: apply rst=0 for 2 cycles with req=1111 → all outputs 0 and busy=0. After release, first grant is gnt=0001.
- Single job: req=0001, pronto=1 → control word per state as above on cycles 1–8, busy on cycles 1–10, ack=0001 and err=0 on cycle 10, IDLE on cycle 11.
- Simultaneous requests: req=0011 held, each requester drops its bit the cycle after its ack → gnt=0001 first, then gnt=0010. Two ack pulses 11 cycles apart.
- Fairness: req=1111 held continuously → grant order 0,1,2,3,0 with sel_id 0,1,2,3,0. No requester is granted twice before the others.
- Timeout: WAIT_MAX=15, pronto=0 → exactly 15 WAITP cycles, then ack with err=1. Repeat with pronto=1 on the 15th WAITP cycle → ack with err=0.
- Reset mid-job: rst=0 during S3 → next cycle IDLE with all outputs 0 and no ack. Re-request req=0100 → gnt=0100 and full sequence.
